// File: rtl/mul_div_unit_if.sv
// Request descriptor package and handshake interface for mul_div_unit.
//
// mul_div_unit_pkg
//   mbus_req_t : dw (1 = 64-bit, 0 = 32-bit), op, ia, ia_orig, ib
//   OP_*       : operation encodings; any other op value behaves as MUL
//
// mul_div_unit_if ports (master = requester, slave = mul_div_unit)
//   req        master->slave  operation descriptor
//   req_valid  master->slave  req holds a new operation
//   is_signed  master->slave  operands are two's complement
//   req_ready  slave->master  unit accepts req this cycle
//   resp_valid slave->master  resp_data holds a finished result
//   resp_data  slave->master  64-bit result
//   resp_ready master->slave  consumer takes the result
//   flush      master->slave  abandon the in-flight operation

package mul_div_unit_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    typedef struct packed {
        logic            dw;
        logic [1:0]      op;
        logic [XLEN-1:0] ia;
        logic [XLEN-1:0] ia_orig;
        logic [XLEN-1:0] ib;
    } mbus_req_t;

endpackage

interface mul_div_unit_if;

    import mul_div_unit_pkg::*;

    mbus_req_t       req;
    logic            req_valid;
    logic            is_signed;
    logic            req_ready;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_ready;
    logic            flush;

    modport master (
        output req, req_valid, is_signed, resp_ready, flush,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req, req_valid, is_signed, resp_ready, flush,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply / divide unit: radix-2 shift-add multiply and restoring
// division on operand magnitudes, one bit per cycle, with a sign fix-up on
// the final cycle. FSM IDLE -> CALC (N cycles) -> DONE -> IDLE, where
// N = 64 for dw=1 and 32 for dw=0.
//
// Ports
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mul_div_unit_if.slave (req/req_valid/is_signed in,
//           req_ready/resp_valid/resp_data out, resp_ready/flush in)
//
// Configuration
//   MDU_EARLY_OUT_EN : when defined, a request whose active-width ia or ib
//                      is zero skips CALC and goes straight to DONE.
//                      Results are identical with or without it.

module mul_div_unit (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned HALF  = 32;
    localparam int unsigned CNT_W = 7;

    // Mirrors mul_div_unit_pkg encodings; anything else is MUL.
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [HALF-1:0] v);
        return {{(XLEN-HALF){v[HALF-1]}}, v};
    endfunction

    // Registers
    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [XLEN-1:0]  a_q,           a_d;           // multiplicand / dividend-quotient
    logic [XLEN-1:0]  b_q,           b_d;           // multiplier / divisor
    logic [XLEN-1:0]  acc_q,         acc_d;         // product / partial remainder
    logic [XLEN-1:0]  special_val_q, special_val_d;
    logic             special_q,     special_d;
    logic             is_div_q,      is_div_d;
    logic             is_rem_q,      is_rem_d;
    logic             dw_q,          dw_d;
    logic             neg_quo_q,     neg_quo_d;     // product / quotient sign
    logic             neg_rem_q,     neg_rem_d;     // remainder sign
    logic             req_ready_q,   req_ready_d;
    logic             resp_valid_q,  resp_valid_d;
    logic [XLEN-1:0]  resp_data_q,   resp_data_d;

    // Request decode: active-width operands, magnitudes and special cases
    logic            in_dw;
    logic            in_signed;
    logic            in_div;
    logic            in_rem;
    logic            in_divrem;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_sa;
    logic            in_sb;
    logic [XLEN-1:0] in_ma;
    logic [XLEN-1:0] in_mb;
    logic [XLEN-1:0] in_min_neg;
    logic            in_div_zero;
    logic            in_ovf;
    logic [XLEN-1:0] in_special_val;

    always_comb begin
        in_dw     = bus.req.dw;
        in_signed = bus.is_signed;
        in_div    = (bus.req.op == OP_DIV);
        in_rem    = (bus.req.op == OP_REM);
        in_divrem = in_div | in_rem;

        if (in_dw) begin
            in_a = bus.req.ia;
            in_b = bus.req.ib;
        end else if (in_signed) begin
            in_a = sext32(bus.req.ia[HALF-1:0]);
            in_b = sext32(bus.req.ib[HALF-1:0]);
        end else begin
            in_a = {{(XLEN-HALF){1'b0}}, bus.req.ia[HALF-1:0]};
            in_b = {{(XLEN-HALF){1'b0}}, bus.req.ib[HALF-1:0]};
        end

        in_sa = in_signed & in_a[XLEN-1];
        in_sb = in_signed & in_b[XLEN-1];
        in_ma = in_sa ? -in_a : in_a;
        in_mb = in_sb ? -in_b : in_b;

        // Most-negative value at the active width, already sign-extended
        in_min_neg  = in_dw ? {1'b1, {(XLEN-1){1'b0}}}
                            : {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        in_div_zero = in_divrem & (in_b == '0);
        in_ovf      = in_divrem & in_signed & (in_a == in_min_neg) & (in_b == '1);

        if (in_div_zero) begin
            if (in_div) begin
                in_special_val = '1;
            end else begin
                in_special_val = in_dw ? bus.req.ia_orig : sext32(bus.req.ia_orig[HALF-1:0]);
            end
        end else begin
            in_special_val = in_div ? in_a : '0;
        end
    end

`ifdef MDU_EARLY_OUT_EN
    // Zero operand: the answer is either the divide-by-zero value or 0
    logic            in_zero_opnd;
    logic [XLEN-1:0] in_early_val;

    always_comb begin
        in_zero_opnd = (in_a == '0) || (in_b == '0);
        in_early_val = in_div_zero ? in_special_val : '0;
    end
`endif

    // One datapath iteration plus the signed, width-adjusted final result
    logic [XLEN:0]   r_sh;
    logic [XLEN-1:0] step_a;
    logic [XLEN-1:0] step_b;
    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] res_raw;
    logic [XLEN-1:0] res_final;

    always_comb begin
        r_sh = {acc_q, a_q[XLEN-1]};
        if (is_div_q || is_rem_q) begin
            // Restoring step: shift in next dividend bit, subtract if it fits
            step_b = b_q;
            if (r_sh >= {1'b0, b_q}) begin
                step_acc = XLEN'(r_sh - {1'b0, b_q});
                step_a   = {a_q[XLEN-2:0], 1'b1};
            end else begin
                step_acc = r_sh[XLEN-1:0];
                step_a   = {a_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc = acc_q + (b_q[0] ? a_q : '0);
            step_a   = {a_q[XLEN-2:0], 1'b0};
            step_b   = {1'b0, b_q[XLEN-1:1]};
        end

        if (is_div_q) begin
            res_raw = neg_quo_q ? -step_a : step_a;
        end else if (is_rem_q) begin
            res_raw = neg_rem_q ? -step_acc : step_acc;
        end else begin
            res_raw = neg_quo_q ? -step_acc : step_acc;
        end

        res_final = dw_q ? res_raw : sext32(res_raw[HALF-1:0]);
        if (special_q) begin
            res_final = special_val_q;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        special_val_d = special_val_q;
        special_d     = special_q;
        is_div_d      = is_div_q;
        is_rem_d      = is_rem_q;
        dw_d          = dw_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        resp_data_d   = resp_data_q;

        case (state_q)
            S_IDLE: begin
                // flush is a no-op here
                if (bus.req_valid && req_ready_q) begin
                    is_div_d      = in_div;
                    is_rem_d      = in_rem;
                    dw_d          = in_dw;
                    neg_quo_d     = in_sa ^ in_sb;
                    neg_rem_d     = in_sa;
                    special_d     = in_div_zero | in_ovf;
                    special_val_d = in_special_val;
                    // 32-bit division starts with the dividend in the top half
                    a_d           = (in_divrem && !in_dw) ? (in_ma << HALF) : in_ma;
                    b_d           = in_mb;
                    acc_d         = '0;
                    cnt_d         = in_dw ? CNT_W'(XLEN) : CNT_W'(HALF);
                    state_d       = S_CALC;
`ifdef MDU_EARLY_OUT_EN
                    if (in_zero_opnd) begin
                        resp_data_d = in_early_val;
                        state_d     = S_DONE;
                    end
`endif
                end
            end

            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        resp_data_d = res_final;
                        state_d     = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // flush wins over resp_ready; the result is dropped either way
                if (bus.flush || bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            special_val_q <= '0;
            special_q     <= 1'b0;
            is_div_q      <= 1'b0;
            is_rem_q      <= 1'b0;
            dw_q          <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            special_val_q <= special_val_d;
            special_q     <= special_d;
            is_div_q      <= is_div_d;
            is_rem_q      <= is_rem_d;
            dw_q          <= dw_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule
